// File: rtl/mem_dump_reader_pkg.sv
// Shared definitions for the result-memory dump reader: FSM encoding and
// default geometry matching the result memory and the preload writer.
package mem_dump_reader_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 2500;
    localparam int CSUM_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_dump_reader_skid_fifo2.sv
// Two-entry skid FIFO. head is the oldest entry; push and pop may coincide at
// any occupancy, and a push into a full FIFO without a pop is dropped.
module mem_dump_reader_skid_fifo2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic [1:0]   cnt;
    logic         do_pop;

    assign do_pop = pop && (cnt != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        slot0 <= push_data;
                        cnt   <= 2'd1;
                    end else if (cnt == 2'd1) begin
                        slot1 <= push_data;
                        cnt   <= 2'd2;
                    end
                end
                2'b01: begin
                    slot0 <= slot1;
                    cnt   <= cnt - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new entry lands behind whatever remains.
                    if (cnt == 2'd1) begin
                        slot0 <= push_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count = cnt;
    assign head  = slot0;

endmodule

// File: rtl/mem_dump_reader.sv
// Sequentially reads DEPTH bytes from the result memory after start, streams
// them on a valid/ready byte port and keeps a running checksum.
module mem_dump_reader
    import mem_dump_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CSUM_W = CSUM_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [CSUM_W-1:0] checksum,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = ADDR_W + 1;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  issue_cnt;
    logic [ADDR_W-1:0] last_addr;
    logic              inflight;
    logic              inflight_last;
    logic [CSUM_W-1:0] csum;
    logic [1:0]        fifo_count;
    logic [DATA_W:0]   fifo_head;
    logic              pop;
    logic [2:0]        occ;
    logic              issue;
    logic              last_issue;
    logic              start_ok;

    // Handshake: a byte transfers in any cycle with out_valid && out_ready;
    // out_valid never drops and out_data/out_last never change until then.
    assign pop        = out_valid && out_ready;
    assign occ        = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue      = (state == RUN) && (issue_cnt < CNT_W'(DEPTH)) && (occ < 3'd2);
    assign last_issue = (issue_cnt == CNT_W'(DEPTH - 1));
    assign start_ok   = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = RUN;
            RUN:        if (issue && last_issue) state_nxt = DRAIN;
            DRAIN:      if (pop && out_last) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN) || (state == DRAIN);
        done      = (state == DONE);
        dbg_state = state;
        // Show the address being read this cycle, otherwise the last one read.
        rd_addr   = issue ? issue_cnt[ADDR_W-1:0] : last_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt     <= '0;
            last_addr     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            csum          <= '0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && last_issue;
            if (start_ok) begin
                issue_cnt <= '0;
                last_addr <= '0;
                csum      <= '0;
            end else begin
                if (issue) begin
                    issue_cnt <= issue_cnt + CNT_W'(1);
                    last_addr <= issue_cnt[ADDR_W-1:0];
                end
                if (pop) begin
                    csum <= csum + CSUM_W'(out_data);
                end
            end
        end
    end

    mem_dump_reader_skid_fifo2 #(
        .W (DATA_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({inflight_last, rd_data}),
        .pop       (pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_head[DATA_W-1:0];
    assign out_last  = out_valid && fifo_head[DATA_W];
    assign checksum  = csum;

endmodule
